instr_encoder: RTL
==================

# instr_encoder

Encodes decoded RV32I instruction fields back into 32-bit instruction words. It is the inverse of the core's immediate generator and uses the same `imm_sel` encoding. Fields arrive over a valid/ready handshake, are range-checked, packed, and queued in a 2-entry output buffer. Each packed word carries a running instruction-memory address. The block feeds the self-test program loader and the instruction-memory write port.

## Interface
- `ADDR_W`, 32: width of the address counter and `out_addr`.
- `BASE_ADDR`, 32'h0000_0000: address given to the first word after reset or `clr`.
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `clr`, input, 1: synchronous flush. Empties the buffer, reloads the address to `BASE_ADDR`, and clears error state.
- `in_valid`, input, 1: the input fields are valid this cycle.
- `in_ready`, output, 1: the block can accept an input this cycle.
- `in_sel`, input, 3: instruction type. 000 I, 001 S, 010 B, 011 U, 100 J, 101 R, 110 L (load). 111 is illegal.
- `in_opcode`, input, 7: opcode, copied into bits [6:0].
- `in_rd`, `in_rs1`, `in_rs2`, input, 5 each: register indices.
- `in_funct3`, input, 3: funct3 field.
- `in_funct7`, input, 7: funct7 field. Used for R-type and for I-type shifts.
- `in_imm`, input, 32: two's-complement immediate value (a byte offset for B and J; the full 32-bit value for U).
- `out_valid`, output, 1: the buffer head holds a word.
- `out_ready`, input, 1: the consumer takes the head word this cycle.
- `out_instr`, output, 32: the encoded word at the buffer head.
- `out_addr`, output, ADDR_W: the address attached to the head word.
- `err_sticky`, output, 1: set on any rejected input. Cleared only by `rst` or `clr`.
- `err_cnt`, output, 8: count of rejected inputs, saturating at 255.

## Operation
- An input is accepted when `in_valid && in_ready`. An output is taken when `out_valid && out_ready`.
- `in_ready` = `!clr && count < 2`. It is computed from registered count only, so it does not depend combinationally on `out_ready`.
- Bit packing follows standard RV32I, with opcode in [6:0]:
  - R: funct7, rs2, rs1, funct3, rd.
  - I and L: imm[11:0], rs1, funct3, rd.
  - I-shift (funct3 = 001 or 101): funct7, shamt = imm[4:0], rs1, funct3, rd.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0].
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11].
  - U: imm[31:12], rd.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd.
- Range checks. A failing input is rejected:
  - I and L: imm must lie in [-2048, 2047].
  - I-shift: imm[31:5] must be 0.
  - S: imm must lie in [-2048, 2047].
  - B: imm must lie in [-4096, 4094] and be even.
  - U: imm[11:0] must be 0.
  - J: imm must lie in [-2^20, 2^20-2] and be even.
  - R: imm is ignored.
  - `in_sel` = 111 is always rejected.
- A rejected input completes its handshake but is not pushed. The address counter does not advance; `err_sticky` is set and `err_cnt` increments.
- Each push stores `{instr, addr}` and then advances the address counter by 4. The counter wraps modulo 2^ADDR_W.
- The buffer is FIFO ordered. A push and a pop in the same cycle leave the count unchanged.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_instr`=0, `out_addr`=0, `err_sticky`=0, `err_cnt`=0. The internal address counter resets to `BASE_ADDR`.
- Latency: an input accepted in cycle N appears with `out_valid`=1 in cycle N+1 when the buffer was empty.
- Throughput: one word per cycle while `out_ready` is held high.
- `clr` has priority over a same-cycle push, pop and error update. All three are discarded.
- Asserting `rst` mid-stream discards buffered words immediately (asynchronously).
- Full buffer (count = 2): `in_ready`=0. A pop in that cycle makes `in_ready`=1 in the next cycle.
- `err_cnt` holds at 255 on further rejects.

## Configuration
- `INSTR_ENC_RANGE_CHECK_EN`
  - Defined: all range checks and the error outputs are active.
  - Undefined: no checking. Immediates are truncated silently to the field bits; every accepted input is pushed; `err_sticky` and `err_cnt` are tied to 0.

## Structure
- `rv32i_pkg` holds:
  - the `imm_sel_e` enum (values 000–111 as above);
  - opcode constants;
  - the shift funct3 constants `F3_SLL`=001 and `F3_SR`=101.
- One combinational sub-module, `instr_pack`, takes the fields and produces `instr[31:0]` plus `range_err`.
- The top level holds the handshake logic, the 2-entry buffer, the address counter and the error logic.

## Test plan
- Encode `addi x1,x0,5`: I type, opcode 0010011, rd 1, funct3 000, imm 5. Expect 0x00500093 at address `BASE_ADDR`.
- Encode `sw x2,8(x1)`: S type, opcode 0100011, funct3 010, rs1 1, rs2 2, imm 8. Expect 0x0020A423.
- Encode `beq x0,x0,-4`: B type, opcode 1100011, imm -4. Expect 0xFE000EE3. Then encode `jal x1,2048`: J type, opcode 1101111, rd 1. Expect 0x001000EF at address `BASE_ADDR`+4.
- Encode `lui x5,0x12345000`: U type, opcode 0110111, rd 5. Expect 0x123452B7. Then send a U-type input with imm 0x12345001. Expect it rejected: no push, `err_cnt`=1, `err_sticky`=1.
- Backpressure: hold `out_ready`=0 and offer 3 inputs back-to-back. Expect 2 accepted, then `in_ready`=0. Release `out_ready`. Expect words in order with addresses +0 and +4, then the third word at +8.
- Drive `clr` in the same cycle as a valid push with 1 word already buffered. Expect `out_valid`=0 next cycle and the next accepted word at `BASE_ADDR`.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding definitions for the instruction encoder.
//   imm_sel_e : instruction-type selector, same encoding as the core's
//               immediate generator (000 I ... 110 L, 111 illegal)
//   OPC_*     : base opcode constants
//   F3_SLL/F3_SR : funct3 values that turn an I-type into a shift
package rv32i_pkg;

  typedef enum logic [2:0] {
    SEL_I   = 3'b000,
    SEL_S   = 3'b001,
    SEL_B   = 3'b010,
    SEL_U   = 3'b011,
    SEL_J   = 3'b100,
    SEL_R   = 3'b101,
    SEL_L   = 3'b110,
    SEL_ILL = 3'b111
  } imm_sel_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: purely combinational RV32I field packer.
//   sel_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i : fields
//   instr_o     : packed 32-bit instruction word
//   range_err_o : immediate does not fit the selected format (or sel is 111)
// Configuration macro: INSTR_ENC_RANGE_CHECK_EN. When undefined,
// range_err_o is forced low and immediates are silently truncated.
module instr_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        range_err_o
);

  imm_sel_e sel;
  logic     is_shift;
  logic     fits12;
  logic     fits13;
  logic     fits21;

  assign sel      = imm_sel_e'(sel_i);
  assign is_shift = (funct3_i == F3_SLL) || (funct3_i == F3_SR);

  // A value fits an N-bit signed field when every bit from N-1 upward
  // is a copy of the sign.
  assign fits12 = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
  assign fits13 = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
  assign fits21 = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);

  always_comb begin
    instr_o     = {25'b0, opcode_i};
    range_err_o = 1'b0;
    case (sel)
      SEL_I: begin
        if (is_shift) begin
          instr_o     = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
          range_err_o = (imm_i[31:5] != '0);
        end else begin
          instr_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
          range_err_o = !fits12;
        end
      end
      // Loads never use the shift layout: funct3 001/101 are lh/lhu.
      SEL_L: begin
        instr_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        range_err_o = !fits12;
      end
      SEL_S: begin
        instr_o     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        range_err_o = !fits12;
      end
      SEL_B: begin
        instr_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
        range_err_o = !fits13 || imm_i[0];
      end
      SEL_U: begin
        instr_o     = {imm_i[31:12], rd_i, opcode_i};
        range_err_o = (imm_i[11:0] != '0);
      end
      SEL_J: begin
        instr_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        range_err_o = !fits21 || imm_i[0];
      end
      SEL_R: begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      default: begin
        range_err_o = 1'b1;
      end
    endcase
`ifndef INSTR_ENC_RANGE_CHECK_EN
    range_err_o = 1'b0;
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts decoded RV32I fields over valid/ready, packs them
// into a 32-bit word, tags each word with a running address and queues
// {instr, addr} in a 2-entry FIFO.
//   clk, rst (async, active high), clr (sync flush)
//   in_valid/in_ready + in_sel, in_opcode, in_rd, in_rs1, in_rs2,
//   in_funct3, in_funct7, in_imm : input fields
//   out_valid/out_ready + out_instr, out_addr : buffer head
//   err_sticky, err_cnt : rejected-input status
// Configuration macro: INSTR_ENC_RANGE_CHECK_EN enables range checking and
// the error outputs; undefined ties err_sticky/err_cnt to 0.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_sel,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_sticky,
  output logic [7:0]        err_cnt
);

  logic [31:0]       packed_instr;
  logic              range_err;
  logic              accept;
  logic              push;
  logic              pop;

  logic [31:0]       instr_q [2];
  logic [ADDR_W-1:0] tag_q   [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q,  count_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;

  instr_pack u_pack (
    .sel_i       (in_sel),
    .opcode_i    (in_opcode),
    .rd_i        (in_rd),
    .rs1_i       (in_rs1),
    .rs2_i       (in_rs2),
    .funct3_i    (in_funct3),
    .funct7_i    (in_funct7),
    .imm_i       (in_imm),
    .instr_o     (packed_instr),
    .range_err_o (range_err)
  );

  // Ready looks only at the registered count (and clr) so the consumer's
  // out_ready never ripples combinationally back to the producer.
  assign in_ready  = !clr && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !range_err;
  assign pop       = out_valid && out_ready;

  // The head outputs read zero while the buffer is empty.
  assign out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_addr  = out_valid ? tag_q[rd_ptr_q]   : '0;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    if (clr) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      addr_d   = BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr_d = !wr_ptr_q;
        addr_d   = addr_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = !rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      addr_q   <= BASE_ADDR;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      if (push && !clr) begin
        instr_q[wr_ptr_q] <= packed_instr;
        tag_q[wr_ptr_q]   <= addr_q;
      end
    end
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic       err_sticky_q;
  logic [7:0] err_cnt_q;

  // A rejected input still completes its handshake; only the error state moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else if (clr) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else if (accept && range_err) begin
      err_sticky_q <= 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
`else
  assign err_sticky = 1'b0;
  assign err_cnt    = 8'd0;
`endif

endmodule
